// File: rtl/simd_loop_cfg_issuer_if.sv
// Loop-config bus between the SIMD decoder/controller side and the config issuer.
// The issuer is the master: it drives config writes, start, block_done and status.
interface simd_loop_cfg_issuer_if #(
    parameter int LOOP_ID_W   = 5,
    parameter int GROUP_ID_W  = 2,
    parameter int LOOP_ITER_W = 16
);
    logic                   instr_v;
    logic                   instr_ready;
    logic                   instr_is_end;
    logic [GROUP_ID_W-1:0]  instr_group_id;
    logic [LOOP_ITER_W-1:0] instr_trip_cnt;
    logic                   cfg_loop_iter_v;
    logic [LOOP_ITER_W-1:0] cfg_loop_iter;
    logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id;
    logic [GROUP_ID_W-1:0]  cfg_loop_group_id;
    logic                   start;
    logic                   done;
    logic                   block_done;
    logic                   busy;
    logic [1:0]             cfg_err;

    modport master (
        input  instr_v, instr_is_end, instr_group_id, instr_trip_cnt, done,
        output instr_ready, cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id,
               cfg_loop_group_id, start, block_done, busy, cfg_err
    );

    modport slave (
        output instr_v, instr_is_end, instr_group_id, instr_trip_cnt, done,
        input  instr_ready, cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id,
               cfg_loop_group_id, start, block_done, busy, cfg_err
    );
endinterface

// File: rtl/simd_loop_cfg_issuer.sv
// Issues per-group loop-config writes from decoded descriptors, then sequences
// each block through start / wait-for-done / block_done.
module simd_loop_cfg_issuer #(
    parameter int LOOP_ID_W   = 5,
    parameter int GROUP_ID_W  = 2,
    parameter int LOOP_ITER_W = 16,
    parameter int TIMEOUT_W   = 20
) (
    input  logic clk,
    input  logic reset,
    simd_loop_cfg_issuer_if.master bus
);
    localparam int NUM_GROUPS = 1 << GROUP_ID_W;
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    typedef enum logic [1:0] {IDLE, START, RUN, FLUSH} state_t;

    state_t                             state, state_nxt;
    logic [NUM_GROUPS-1:0][LOOP_ID_W:0] cnt;
    logic [TIMEOUT_W-1:0]               wd;
    logic [LOOP_ID_W:0]                 sel_cnt;
    logic                               acc, loop_acc, end_acc, full, timeout;

    assign acc      = bus.instr_v && bus.instr_ready;
    assign loop_acc = acc && !bus.instr_is_end;
    assign end_acc  = acc && bus.instr_is_end;
    assign sel_cnt  = cnt[bus.instr_group_id];
    assign full     = sel_cnt[LOOP_ID_W];
    // wd equals the number of RUN cycles elapsed, so timeout lands on RUN cycle WD_MAX
    assign timeout  = (state == RUN) && !bus.done && (wd == WD_MAX);

    assign bus.instr_ready = (state == IDLE) && !reset;
    assign bus.start       = (state == START);
    assign bus.block_done  = (state == FLUSH);
    assign bus.busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (end_acc) state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (bus.done || wd == WD_MAX) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cfg_loop_iter_v       <= 1'b0;
            bus.cfg_loop_iter         <= '0;
            bus.cfg_loop_iter_loop_id <= '0;
            bus.cfg_loop_group_id     <= '0;
            bus.cfg_err               <= 2'b00;
            cnt                       <= '0;
            wd                        <= '0;
        end else begin
            bus.cfg_loop_iter_v       <= 1'b0;
            bus.cfg_loop_iter         <= '0;
            bus.cfg_loop_iter_loop_id <= '0;
            bus.cfg_loop_group_id     <= '0;
            if (loop_acc) begin
                if (full) begin
                    bus.cfg_err[0] <= 1'b1;
                end else begin
                    bus.cfg_loop_iter_v       <= 1'b1;
                    bus.cfg_loop_iter         <= (bus.instr_trip_cnt == '0) ? '0
                                                 : bus.instr_trip_cnt - 1'b1;
                    bus.cfg_loop_iter_loop_id <= sel_cnt[LOOP_ID_W-1:0];
                    bus.cfg_loop_group_id     <= bus.instr_group_id;
                    cnt[bus.instr_group_id]   <= sel_cnt + 1'b1;
                    if (bus.instr_trip_cnt == '0) bus.cfg_err[0] <= 1'b1;
                end
            end
            case (state)
                IDLE:    wd <= '0;
                START:   wd <= wd + 1'b1;
                RUN: begin
                    wd <= wd + 1'b1;
                    if (timeout) bus.cfg_err[1] <= 1'b1;
                end
                FLUSH:   cnt <= '0;
                default: wd <= '0;
            endcase
        end
    end
endmodule
